branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/bru_pkg.sv | 17 +
 rtl/bru_upd_fifo.sv | 54 +++++
 rtl/branch_resolve_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
// Shared types and defaults for the branch resolve unit.
package bru_pkg;

    localparam int unsigned BRU_FIFO_DEPTH = 4;
    localparam int unsigned BRU_CNT_W      = 16;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        REDIR = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } bru_upd_t;

endpackage

// File: rtl/bru_upd_fifo.sv
// Pending BTB update queue: power-of-two depth, explicit occupancy count.
module bru_upd_fifo
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = BRU_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  bru_upd_t push_data,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output bru_upd_t head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    bru_upd_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches, issues fetch redirects and queues BTB updates.
// Mispredict counter is present only when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = BRU_FIFO_DEPTH,
    parameter int unsigned CNT_W      = BRU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_valid,
    input  logic [31:0]      ex_pred_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             update_req,
    output logic [31:0]      update_pc,
    output logic [31:0]      update_target,
    input  logic             update_stall,
    output logic [CNT_W-1:0] mispredict_count
);

    bru_state_e  state_q;
    bru_state_e  state_d;
    logic        accept;
    logic        taken_miss;
    logic        mispredict;
    logic        fifo_full;
    logic        fifo_empty;
    bru_upd_t    push_entry;
    bru_upd_t    head_entry;
    logic [31:0] redirect_pc_q;

    assign ex_ready   = (state_q == RUN) && !fifo_full;
    assign accept     = ex_valid && ex_ready;
    assign taken_miss = ex_taken && (!ex_pred_valid || (ex_pred_target != ex_target));
    assign mispredict = taken_miss || (!ex_taken && ex_pred_valid);

    assign push_entry.pc     = ex_pc;
    assign push_entry.target = ex_target;

    assign update_req    = !fifo_empty && !update_stall;
    assign update_pc     = head_entry.pc;
    assign update_target = head_entry.target;

    bru_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && taken_miss),
        .push_data (push_entry),
        .pop       (update_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && mispredict)
                redirect_pc_q <= ex_taken ? ex_target : (ex_pc + 32'd4);
        end
    end

    always_comb begin
        state_d        = state_q;
        redirect_valid = 1'b0;
        case (state_q)
            RUN: begin
                if (accept && mispredict) state_d = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                state_d        = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign redirect_pc = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && mispredict && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign mispredict_count = cnt_q;
`else
    assign mispredict_count = '0;
`endif

endmodule
